// File: rtl/param_accumulator_register.sv
// Multi-mode WIDTH-bit accumulator register: load, clear, set, shifts, inc/dec,
// with registered carry/zero flags and a one-cycle update strobe.
module param_accumulator_register #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit              ARITH_SHR   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero,
    output logic             updated
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SET   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_INC   = 3'b110;
    localparam logic [2:0] OP_DEC   = 3'b111;

    localparam logic ZERO_AT_RESET = (RESET_VALUE == '0);

    logic [WIDTH-1:0] reg_q, reg_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             updated_q, updated_d;

    // One extra bit on the arithmetic paths captures the carry/borrow out.
    logic [WIDTH:0]   inc_w;
    logic [WIDTH:0]   dec_w;
    logic             shr_fill;

    assign inc_w    = {1'b0, reg_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w    = {1'b0, reg_q} - {{WIDTH{1'b0}}, 1'b1};
    assign shr_fill = ARITH_SHR ? reg_q[WIDTH-1] : serial_in;

    always_comb begin
        reg_d     = reg_q;
        carry_d   = carry_q;
        updated_d = 1'b0;
        if (enable) begin
            updated_d = (op != OP_HOLD);
            case (op)
                OP_LOAD: begin
                    reg_d   = d;
                    carry_d = 1'b0;
                end
                OP_CLEAR: begin
                    reg_d   = '0;
                    carry_d = 1'b0;
                end
                OP_SET: begin
                    reg_d   = '1;
                    carry_d = 1'b0;
                end
                OP_SHL: begin
                    reg_d   = {reg_q[WIDTH-2:0], serial_in};
                    carry_d = reg_q[WIDTH-1];
                end
                OP_SHR: begin
                    reg_d   = {shr_fill, reg_q[WIDTH-1:1]};
                    carry_d = reg_q[0];
                end
                OP_INC: begin
                    reg_d   = inc_w[WIDTH-1:0];
                    carry_d = inc_w[WIDTH];
                end
                OP_DEC: begin
                    reg_d   = dec_w[WIDTH-1:0];
                    carry_d = dec_w[WIDTH];
                end
                default: begin
                    reg_d   = reg_q;
                    carry_d = carry_q;
                end
            endcase
        end
        // Derived from the next value so the registered flag always matches q.
        zero_d = (reg_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_q     <= RESET_VALUE;
            carry_q   <= 1'b0;
            zero_q    <= ZERO_AT_RESET;
            updated_q <= 1'b0;
        end else begin
            reg_q     <= reg_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            updated_q <= updated_d;
        end
    end

    assign q       = reg_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign updated = updated_q;

endmodule

// File: tb/tb_param_accumulator_register.sv
// Directed bench for param_accumulator_register: a logical-shift and an
// arithmetic-shift instance driven from shared inputs.
module tb_param_accumulator_register;

    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'h5A;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] CLEAR = 3'b010;
    localparam logic [2:0] SET   = 3'b011;
    localparam logic [2:0] SHL   = 3'b100;
    localparam logic [2:0] SHR   = 3'b101;
    localparam logic [2:0] INC   = 3'b110;
    localparam logic [2:0] DEC   = 3'b111;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] d = '0;
    logic         serial_in = 1'b0;

    logic [W-1:0] q, q_a;
    logic         carry, carry_a, zero, zero_a, updated, updated_a;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    param_accumulator_register #(.WIDTH(W), .RESET_VALUE(RV), .ARITH_SHR(1'b0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .op(op), .d(d),
        .serial_in(serial_in), .q(q), .carry(carry), .zero(zero), .updated(updated)
    );

    param_accumulator_register #(.WIDTH(W), .RESET_VALUE(RV), .ARITH_SHR(1'b1)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .op(op), .d(d),
        .serial_in(serial_in), .q(q_a), .carry(carry_a), .zero(zero_a), .updated(updated_a)
    );

    typedef struct {
        string      name;
        logic       en;
        logic [2:0] op;
        logic [7:0] d;
        logic       si;
        logic [7:0] exp_q;
        logic       exp_c;
        logic       exp_z;
        logic       exp_u;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] eq, input logic ec,
                             input logic ez, input logic eu);
        check({name, ".q"}, q, eq);
        check({name, ".carry"}, {7'd0, carry}, {7'd0, ec});
        check({name, ".zero"}, {7'd0, zero}, {7'd0, ez});
        check({name, ".updated"}, {7'd0, updated}, {7'd0, eu});
    endtask

    task automatic apply(input logic en, input logic [2:0] o, input logic [7:0] dv, input logic si);
        enable    = en;
        op        = o;
        d         = dv;
        serial_in = si;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs.push_back('{"load0",      1, LOAD,  8'h00, 0, 8'h00, 0, 1, 1});
        vecs.push_back('{"hold_en0_a", 0, LOAD,  8'hFF, 0, 8'h00, 0, 1, 0});
        vecs.push_back('{"hold_en0_b", 0, LOAD,  8'hFF, 0, 8'h00, 0, 1, 0});
        vecs.push_back('{"hold_en0_c", 0, LOAD,  8'hFF, 0, 8'h00, 0, 1, 0});
        vecs.push_back('{"loadFF",     1, LOAD,  8'hFF, 0, 8'hFF, 0, 0, 1});
        vecs.push_back('{"inc_wrap",   1, INC,   8'h00, 0, 8'h00, 1, 1, 1});
        vecs.push_back('{"dec_wrap",   1, DEC,   8'h00, 0, 8'hFF, 1, 0, 1});
        vecs.push_back('{"dec_plain",  1, DEC,   8'h00, 0, 8'hFE, 0, 0, 1});
        vecs.push_back('{"inc_plain",  1, INC,   8'h00, 0, 8'hFF, 0, 0, 1});
        vecs.push_back('{"load81",     1, LOAD,  8'h81, 0, 8'h81, 0, 0, 1});
        vecs.push_back('{"shl_si1",    1, SHL,   8'h00, 1, 8'h03, 1, 0, 1});
        vecs.push_back('{"shr_si0",    1, SHR,   8'h00, 0, 8'h01, 1, 0, 1});
        vecs.push_back('{"shl_si0",    1, SHL,   8'h00, 0, 8'h02, 0, 0, 1});
        vecs.push_back('{"set",        1, SET,   8'h00, 0, 8'hFF, 0, 0, 1});
        vecs.push_back('{"clear",      1, CLEAR, 8'h55, 1, 8'h00, 0, 1, 1});
        vecs.push_back('{"hold_op",    1, HOLD,  8'hFF, 1, 8'h00, 0, 1, 0});
        vecs.push_back('{"dec_from0",  1, DEC,   8'h00, 0, 8'hFF, 1, 0, 1});
        vecs.push_back('{"en0_carry",  0, INC,   8'h00, 0, 8'hFF, 1, 0, 0});
        vecs.push_back('{"hold_carry", 1, HOLD,  8'h00, 0, 8'hFF, 1, 0, 0});
        vecs.push_back('{"shr_si1",    1, SHR,   8'h00, 1, 8'hFF, 1, 0, 1});

        // Reset asserted between edges takes effect without a clock.
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_all("reset_async", RV, 1'b0, 1'b0, 1'b0);
        check("reset_async_a.q", q_a, RV);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].op, vecs[i].d, vecs[i].si);
            check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_c, vecs[i].exp_z, vecs[i].exp_u);
        end

        // Arithmetic versus logical right shift.
        apply(1, LOAD, 8'h80, 0);
        apply(1, SHR, 8'h00, 0);
        check("ashr80.q", q_a, 8'hC0);
        check("ashr80.carry", {7'd0, carry_a}, 8'h00);
        check("lshr80.q", q, 8'h40);
        apply(1, SHR, 8'h00, 0);
        check("ashrC0.q", q_a, 8'hE0);
        apply(1, LOAD, 8'h01, 0);
        apply(1, SHR, 8'h00, 1);
        check("ashr01.q", q_a, 8'h00);
        check("ashr01.carry", {7'd0, carry_a}, 8'h01);
        check("ashr01.zero", {7'd0, zero_a}, 8'h01);
        check("lshr01_si1.q", q, 8'h80);
        check("lshr01_si1.carry", {7'd0, carry}, 8'h01);

        // Reset mid-sequence aborts counting; first edge after release increments RV.
        apply(1, LOAD, 8'h10, 0);
        apply(1, INC, 8'h00, 0);
        apply(1, INC, 8'h00, 0);
        check_all("inc_seq", 8'h12, 1'b0, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_all("reset_mid", RV, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_all("reset_held_edge", RV, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_all("inc_after_reset", RV + 8'h01, 1'b0, 1'b0, 1'b1);
        apply(1, HOLD, 8'h00, 0);
        check_all("hold_after_reset", RV + 8'h01, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_accumulator_register.md
Name: param_accumulator_register

Overview:
- Parametrised multi-mode register for the accumulator datapath.
- Generalises the single-bit D flip-flop to WIDTH bits.
- Adds operations selected per cycle: load, clear, set-all-ones, shift left/right with serial fill, increment and decrement.
- Adds registered carry and zero flags and a one-cycle update strobe for the control unit.

Parameters:
- WIDTH, 8, data width in bits (minimum 2).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).
- ARITH_SHR, 0, 1 = right shift fills the MSB with q[WIDTH-1] (arithmetic); 0 = fills with serial_in (logical/serial).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = execute op on this edge; 0 = hold everything.
- op  input  3  operation select; encoding below.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  fill bit for SHL, and for SHR when ARITH_SHR=0.
- q  output  WIDTH  register contents.
- carry  output  1  registered carry/borrow/shift-out flag.
- zero  output  1  registered flag, 1 when q == 0.
- updated  output  1  one-cycle pulse after any enabled non-HOLD op.

Behaviour:
- Reset is asynchronous and active-high; one clock domain.
- While reset=1, immediately and regardless of clock:
  - q = RESET_VALUE
  - carry = 0
  - zero = (RESET_VALUE == 0)
  - updated = 0
- Reset asserted mid-operation aborts the op; the first op after release executes on the first rising edge with reset=0.
- All outputs are registered and update on the rising edge of clock. Latency is 1 cycle from op/d sampling to q and flags.
- enable=0: q and carry hold, zero stays consistent with q, updated=0. op, d and serial_in are ignored.
- op encoding (enable=1):
  - 000 HOLD: q holds, carry holds, updated=0.
  - 001 LOAD: q <= d; carry <= 0.
  - 010 CLEAR: q <= 0; carry <= 0.
  - 011 SET: q <= all ones; carry <= 0.
  - 100 SHL: q <= {q[WIDTH-2:0], serial_in}; carry <= q[WIDTH-1].
  - 101 SHR: q <= {fill, q[WIDTH-1:1]}; fill = ARITH_SHR ? q[WIDTH-1] : serial_in; carry <= q[0].
  - 110 INC: q <= q+1 modulo 2^WIDTH; carry <= 1 only when old q is all ones (wraps to 0).
  - 111 DEC: q <= q-1 modulo 2^WIDTH; carry (borrow) <= 1 only when old q == 0 (wraps to all ones).
- zero is computed from the next value of q and registered with it, so zero always equals (q == 0) in the same cycle.
- updated: registered; 1 for exactly the cycle following an edge where enable=1 and op != HOLD, else 0. Back-to-back ops keep it high on consecutive cycles.
- Arithmetic is unsigned WIDTH-bit. No saturation; overflow and underflow are reported only through carry.
- No X propagation: every op code is defined; no latches; all state is in the single clocked process.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'h5A; assert reset between edges -> q=8'h5A, carry=0, zero=0, updated=0 immediately, before the next clock edge.
- Load/hold: LOAD d=8'h00 -> next cycle q=0, zero=1, updated=1; then enable=0 with op=LOAD, d=8'hFF for 3 cycles -> q stays 0, updated=0.
- Wrap: LOAD 8'hFF, INC -> q=8'h00, carry=1, zero=1; DEC -> q=8'hFF, carry=1, zero=0; DEC -> q=8'hFE, carry=0.
- Shifts: LOAD 8'h81, SHL serial_in=1 -> q=8'h03, carry=1; SHR serial_in=0 with ARITH_SHR=0 -> q=8'h01, carry=1. Second instance with ARITH_SHR=1: LOAD 8'h80, SHR -> q=8'hC0, carry=0.
- Clear/set and strobe: SET -> q=8'hFF, carry=0; CLEAR -> q=0, zero=1; HOLD -> updated drops to 0 while q stays 0.
- Reset mid-sequence: run INC each cycle from 8'h10, assert reset asynchronously after 2 edges -> q returns to RESET_VALUE without a clock; after release, the first INC edge gives RESET_VALUE+1.
